mem_access_unit: RTL and testbench

//  Load/store sequencer between the multicycle datapath and the unified instruction/data memory.

---
 rtl/mem_access_unit_if.sv | 14 +
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory-side request/acknowledge bus between the load/store sequencer and
// the unified instruction/data memory.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one access per request, byte-enable generation, store
// lane replication, load extension, and misalignment/timeout reporting.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_timeout,
    mem_access_unit_if.master mem
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_t;

    state_t        r_state, w_next;
    logic          r_we, r_tmo;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [CW-1:0] r_cnt;

    logic          w_bad, w_access, w_expire;
    logic [31:0]   w_shift, w_load, w_mwdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_be;

    // Illegal encodings, unsigned stores, and misaligned halves/words all fault.
    always_comb begin
        w_bad = 1'b0;
        case (i_funct3)
            3'b000:  w_bad = 1'b0;
            3'b001:  w_bad = i_addr[0];
            3'b010:  w_bad = |i_addr[1:0];
            3'b100:  w_bad = i_we;
            3'b101:  w_bad = i_we | i_addr[0];
            default: w_bad = 1'b1;
        endcase
    end

    assign w_access = (r_state == S_ACCESS);
    assign w_expire = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_req) w_next = w_bad ? S_FAULT : S_ACCESS;
            S_ACCESS: if (mem.ack || w_expire) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_tmo   <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_tmo <= 1'b0;
                    if (i_req) begin
                        r_we    <= i_we;
                        r_f3    <= i_funct3;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A late ack on the expiry cycle still wins over the timeout.
                    if (mem.ack) begin
                        if (!r_we) r_rdata <= w_load;
                    end else if (w_expire) begin
                        r_tmo <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_shift = mem.rdata >> {r_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? mem.rdata[31:16] : mem.rdata[15:0];

    always_comb begin
        w_load   = mem.rdata;
        w_be     = 4'b1111;
        w_mwdata = r_wdata;
        case (r_f3[1:0])
            2'b00: begin
                w_load   = r_f3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_be     = 4'b0001 << r_addr[1:0];
                w_mwdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_load   = r_f3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_mwdata = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign mem.req      = w_access;
    assign mem.we       = w_access & r_we;
    assign mem.addr     = w_access ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem.be       = w_access ? w_be : 4'd0;
    assign mem.wdata    = w_access ? w_mwdata : 32'd0;

    assign o_rdata      = r_rdata;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE) || (r_state == S_FAULT);
    assign o_misaligned = (r_state == S_FAULT);
    assign o_timeout    = (r_state == S_DONE) && r_tmo;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level expectation model
// and a per-cycle compare process on the falling edge.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] o_rdata;
    logic        o_busy, o_done, o_mis, o_tmo;

    mem_access_unit_if mbus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(o_rdata), .o_busy(o_busy),
        .o_done(o_done), .o_misaligned(o_mis), .o_timeout(o_tmo), .mem(mbus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int reqcnt;
    bit chk_en = 1'b0;

    logic        e_busy, e_done, e_mis, e_tmo, e_mreq, e_mwe;
    logic [31:0] e_rdata, e_maddr, e_mwd;
    logic [3:0]  e_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: rules stated in terms of access size in bytes and byte offset.
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (w && f3[2]) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << size_of(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v, mask;
        int sz;
        sz = size_of(f3);
        if (sz == 4) return w;
        v    = w >> (8 * (a % 4));
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (mbus.req === 1'b1) reqcnt++;
            chk("busy", {31'd0, o_busy}, {31'd0, e_busy});
            chk("done", {31'd0, o_done}, {31'd0, e_done});
            chk("misaligned", {31'd0, o_mis}, {31'd0, e_mis});
            chk("timeout", {31'd0, o_tmo}, {31'd0, e_tmo});
            chk("mem_req", {31'd0, mbus.req}, {31'd0, e_mreq});
            chk("rdata", o_rdata, e_rdata);
            if (e_mreq) begin
                chk("mem_we", {31'd0, mbus.we}, {31'd0, e_mwe});
                chk("mem_addr", mbus.addr, e_maddr);
                chk("mem_be", {28'd0, mbus.be}, {28'd0, e_be});
                chk("mem_wdata", mbus.wdata, e_mwd);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        e_busy = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_tmo = 1'b0; e_mreq = 1'b0;
    endtask

    // One access; ackk = ACCESS cycle carrying the ack (0 = never). hold keeps req high while busy.
    task automatic do_acc(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int ackk, input logic [31:0] rw,
                          input bit hold);
        bit acked;
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        set_idle();
        tick();
        if (is_bad(w, f3, a)) begin
            if (!hold) req = 1'b0;
            e_busy = 1'b1; e_done = 1'b1; e_mis = 1'b1;
            tick();
        end else begin
            acked = 1'b0;
            for (int k = 1; k <= TIMEOUT; k++) begin
                if (!hold) req = 1'b0;
                e_busy = 1'b1; e_done = 1'b0; e_mreq = 1'b1; e_mwe = w;
                e_maddr = {a[31:2], 2'b00}; e_be = model_be(f3, a); e_mwd = model_wd(f3, wd);
                mbus.ack   = (k == ackk);
                mbus.rdata = (k == ackk) ? rw : 32'hA5A5_5A5A;
                tick();
                if (k == ackk) begin
                    acked = 1'b1;
                    break;
                end
            end
            mbus.ack = 1'b0;
            e_mreq = 1'b0; e_done = 1'b1; e_tmo = !acked;
            if (acked && !w) e_rdata = model_load(f3, a, rw);
            tick();
        end
        req = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        mbus.ack = 1'b0; mbus.rdata = 32'd0;
        set_idle(); e_rdata = 32'd0; e_mwe = 1'b0; e_maddr = 32'd0; e_be = 4'd0; e_mwd = 32'd0;
        reqcnt = 0;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // Model pinned against hand-derived values.
        chk("pin be SH 0x202", {28'd0, model_be(3'b001, 32'h202)}, 32'h0000_000C);
        chk("pin wd SH", model_wd(3'b001, 32'h1234_BEEF), 32'hBEEF_BEEF);
        chk("pin be SB 0x101", {28'd0, model_be(3'b000, 32'h101)}, 32'h0000_0002);

        do_acc(1'b0, 3'b010, 32'h100, 32'd0, 3, 32'hDEAD_BEEF, 1'b0);
        chk("LW rdata literal", o_rdata, 32'hDEAD_BEEF);
        do_acc(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h8012_3456, 1'b0);
        chk("LB rdata literal", o_rdata, 32'hFFFF_FF80);
        do_acc(1'b0, 3'b100, 32'h103, 32'd0, 2, 32'h8012_3456, 1'b0);
        chk("LBU rdata literal", o_rdata, 32'h0000_0080);
        do_acc(1'b1, 3'b001, 32'h202, 32'h1234_BEEF, 2, 32'h0, 1'b0);
        chk("store keeps rdata", o_rdata, 32'h0000_0080);

        do_acc(1'b0, 3'b010, 32'h102, 32'd0, 1, 32'h0, 1'b0);
        do_acc(1'b0, 3'b111, 32'h100, 32'd0, 1, 32'h0, 1'b0);
        do_acc(1'b1, 3'b100, 32'h100, 32'h55, 1, 32'h0, 1'b0);
        do_acc(1'b0, 3'b101, 32'h101, 32'd0, 1, 32'h0, 1'b0);

        do_acc(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 1, 32'h0, 1'b0);
        do_acc(1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 1, 32'h0, 1'b0);
        do_acc(1'b0, 3'b001, 32'h102, 32'd0, 4, 32'h8001_7FFF, 1'b0);
        chk("LH rdata literal", o_rdata, 32'hFFFF_8001);
        do_acc(1'b0, 3'b101, 32'h000, 32'd0, 1, 32'h8001_7FFF, 1'b0);
        chk("LHU rdata literal", o_rdata, 32'h0000_7FFF);

        reqcnt = 0;
        do_acc(1'b0, 3'b010, 32'h400, 32'd0, 0, 32'h0, 1'b0);
        chk("timeout req cycles", reqcnt, 32'd16);
        chk("timeout keeps rdata", o_rdata, 32'h0000_7FFF);

        do_acc(1'b0, 3'b010, 32'h404, 32'd0, TIMEOUT, 32'h1357_9BDF, 1'b0);
        chk("ack at expiry literal", o_rdata, 32'h1357_9BDF);

        do_acc(1'b0, 3'b000, 32'h001, 32'd0, 2, 32'h0000_7F00, 1'b1);
        chk("held req literal", o_rdata, 32'h0000_007F);

        // Reset during ACCESS: request drops, no done, rdata cleared.
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h300; wdata = 32'd0;
        tick();
        req = 1'b0;
        e_busy = 1'b1; e_mreq = 1'b1; e_mwe = 1'b0; e_maddr = 32'h300; e_be = 4'hF; e_mwd = 32'd0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b0;
        tick();
        set_idle(); e_rdata = 32'd0;
        rst = 1'b1;
        tick();
        do_acc(1'b0, 3'b010, 32'h300, 32'd0, 2, 32'h0BAD_F00D, 1'b0);
        chk("post-reset LW literal", o_rdata, 32'h0BAD_F00D);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
